decoder_scan_sequencer: RTL and testbench



---
 rtl/decoder_scan_sequencer.sv | 140 ++++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer producing the 3-bit select code for a downstream 3-to-8
// decoder. Walks the set bits of enable_mask in ascending order, holding
// each position for dwell+1 cycles, and wraps continuously.
// Build option: define ONESHOT_EN to scan exactly one frame per start.
//
// state | meaning
// IDLE  | no scan running; sel=0, sel_valid=0, busy=0
// SCAN  | sel holds a live position; dwell counter runs down to zero
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         enable_mask,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               step,
    output logic               frame_done,
    output logic               busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [2:0]         sel_nxt;
    logic               valid_nxt, step_nxt, fd_nxt, busy_nxt;
    logic [2:0]         adv_pos;
    logic               adv_wrap;

    // First set bit strictly above cur, modulo 8; cur itself is found last,
    // so a single-bit mask returns to the same position. Starting from 7
    // yields the lowest set bit.
    function automatic logic [2:0] next_pos(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] p;
        logic [2:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            p = cur + 3'(k);
            if (!found && m[p]) begin
                res   = p;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign adv_pos  = next_pos(enable_mask, sel);
    assign adv_wrap = (adv_pos <= sel);

    // State, counter and all outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 3'b000;
            sel_valid  <= 1'b0;
            step       <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            sel_valid  <= valid_nxt;
            step       <= step_nxt;
            frame_done <= fd_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state and next-output decode; stop overrides start and advance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        valid_nxt = sel_valid;
        busy_nxt  = busy;
        step_nxt  = 1'b0;
        fd_nxt    = 1'b0;
        case (state)
            IDLE: begin
                sel_nxt   = 3'b000;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
                if (start && !stop && (enable_mask != 8'h00)) begin
                    state_nxt = SCAN;
                    sel_nxt   = next_pos(enable_mask, 3'd7);
                    cnt_nxt   = dwell;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    step_nxt  = 1'b1;
                end
            end
            SCAN: begin
                if (stop || (cnt == '0 && enable_mask == 8'h00)) begin
                    state_nxt = IDLE;
                    sel_nxt   = 3'b000;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
`ifdef ONESHOT_EN
                    if (adv_wrap) begin
                        state_nxt = IDLE;
                        sel_nxt   = 3'b000;
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        cnt_nxt   = '0;
                        fd_nxt    = 1'b1;
                    end else begin
                        sel_nxt  = adv_pos;
                        cnt_nxt  = dwell;
                        step_nxt = 1'b1;
                    end
`else
                    sel_nxt  = adv_pos;
                    cnt_nxt  = dwell;
                    step_nxt = 1'b1;
                    fd_nxt   = adv_wrap;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer: a behavioural scan model
// is compared against the DUT on every falling edge, plus directed literal
// checks for reset, full-mask, sparse-mask and zero-mask cases.
module tb_decoder_scan_sequencer;

    localparam int DWELL_W = 8;
`ifdef ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [7:0]         enable_mask = '0;
    logic [2:0]         sel;
    logic               sel_valid, step, frame_done, busy;

    int n_vec = 0;
    int n_err = 0;

    decoder_scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .dwell(dwell), .enable_mask(enable_mask),
        .sel(sel), .sel_valid(sel_valid), .step(step),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: which position is live, how many more cycles it
    // stays, and the pulses produced by the most recent edge.
    bit m_active;
    int m_pos;
    int m_left;
    bit m_step, m_fd;

    function automatic int first_after(input logic [7:0] m, input int cur);
        for (int k = 1; k <= 8; k++)
            if (m[(cur + k) % 8]) return (cur + k) % 8;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_pos = 0; m_left = 0; m_step = 0; m_fd = 0;
        end else begin
            int nxt;
            m_step = 0;
            m_fd   = 0;
            if (!m_active) begin
                if (start && !stop && enable_mask != 0) begin
                    m_active = 1;
                    m_pos    = first_after(enable_mask, 7);
                    m_left   = int'(dwell);
                    m_step   = 1;
                end
            end else if (stop) begin
                m_active = 0;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (enable_mask == 0) begin
                m_active = 0;
            end else begin
                nxt = first_after(enable_mask, m_pos);
                if (ONESHOT && nxt <= m_pos) begin
                    m_active = 0;
                    m_fd     = 1;
                end else begin
                    m_fd   = (nxt <= m_pos);
                    m_pos  = nxt;
                    m_left = int'(dwell);
                    m_step = 1;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_sel",   int'(sel),        m_active ? m_pos : 0);
            check("model_valid", int'(sel_valid),  int'(m_active));
            check("model_busy",  int'(busy),       int'(m_active));
            check("model_step",  int'(step),       int'(m_step));
            check("model_fd",    int'(frame_done), int'(m_fd));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_idle(input string name);
        check({name, "_sel"},   int'(sel), 0);
        check({name, "_valid"}, int'(sel_valid), 0);
        check({name, "_busy"},  int'(busy), 0);
        check({name, "_step"},  int'(step), 0);
        check({name, "_fd"},    int'(frame_done), 0);
    endtask

    int sparse_seq [9] = '{2, 2, 2, 5, 5, 5, 7, 7, 7};

    initial begin
        cyc(2);
        expect_idle("reset_hold");
        rst_n = 1'b1;
        cmp_en = 1;
        cyc(2);
        expect_idle("after_release");

        // Full mask, no dwell: 0..7 then back to 0 with frame_done.
        enable_mask = 8'hFF; dwell = 0; start = 1;
        cyc(1);
        start = 0;
        for (int i = 0; i <= 8; i++) begin
            check("full_sel", int'(sel), i % 8);
            check("full_fd", int'(frame_done), (i == 8) ? 1 : 0);
            if (i < 8) check("full_step", int'(step), 1);
            cyc(1);
        end
        stop = 1; cyc(1); stop = 0; cyc(1);
        expect_idle("stop_full");

        // Sparse mask with dwell 2.
        enable_mask = 8'b1010_0100; dwell = 2; start = 1;
        cyc(1);
        start = 0;
        for (int i = 0; i < 9; i++) begin
            check("sparse_sel", int'(sel), sparse_seq[i]);
            check("sparse_step", int'(step), (i % 3 == 0) ? 1 : 0);
            cyc(1);
        end
        cyc(6);
        stop = 1; cyc(1); stop = 0;
        expect_idle("stop_sparse");

        // Zero mask start is ignored.
        enable_mask = 8'h00; start = 1;
        cyc(3);
        start = 0;
        expect_idle("zero_mask");

        // Single-bit mask with dwell 1.
        enable_mask = 8'b0001_0000; dwell = 1; start = 1;
        cyc(1);
        start = 0;
        check("single_sel", int'(sel), 4);
        cyc(8);

        // Stop mid-hold with dwell 3, then mask cleared mid-scan.
        stop = 1; cyc(1); stop = 0;
        enable_mask = 8'hFF; dwell = 3; start = 1;
        cyc(1); start = 0; cyc(2);
        stop = 1; cyc(1); stop = 0;
        expect_idle("stop_hold");
        start = 1; cyc(1); start = 0; cyc(1);
        enable_mask = 8'h00;
        cyc(6);
        expect_idle("mask_cleared");

        // Asynchronous reset mid-scan, mid-clock.
        enable_mask = 8'hFF; dwell = 1; start = 1;
        cyc(3); start = 0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        expect_idle("async_reset");
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        expect_idle("post_reset_idle");

        // Randomized phase.
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 9) < 3);
            stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: enable_mask = 8'h00;
                    1: enable_mask = 8'h01 << $urandom_range(0, 7);
                    default: enable_mask = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 15) == 0) dwell = DWELL_W'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            cyc(1);
        end

        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
